// File: rtl/rd_delay_pipe.sv
// Multi-stage delay line for destination-register tags with stall/flush and per-stage
// source-tag comparators reporting the youngest matching stage.
module rd_delay_pipe #(
    parameter int WIDTH       = 5,
    parameter int DEPTH       = 3,
    parameter bit IGNORE_ZERO = 1'b1,
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             rs1_hit,
    output logic [SW-1:0]    rs1_hit_stage,
    output logic             rs2_hit,
    output logic [SW-1:0]    rs2_hit_stage,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Invalid stages are kept at zero so out_data never leaks stale tags.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (!stall) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    logic             rs1_ok;
    logic             rs2_ok;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    assign rs1_ok = !(IGNORE_ZERO && (rs1 == '0));
    assign rs2_ok = !(IGNORE_ZERO && (rs2 == '0));

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = valid_q[i] && (data_q[i] == rs1) && rs1_ok;
            match2[i] = valid_q[i] && (data_q[i] == rs2) && rs2_ok;
        end
    end

    // Scan from the oldest stage down so the youngest match is the one that sticks.
    always_comb begin
        rs1_hit       = 1'b0;
        rs1_hit_stage = '0;
        rs2_hit       = 1'b0;
        rs2_hit_stage = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match1[i]) begin
                rs1_hit       = 1'b1;
                rs1_hit_stage = SW'(i);
            end
            if (match2[i]) begin
                rs2_hit       = 1'b1;
                rs2_hit_stage = SW'(i);
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + CW'(valid_q[i]);
        end
    end

endmodule

// File: tb/tb_rd_delay_pipe.sv
// Bench for rd_delay_pipe: directed vector table on the default configuration (plus an
// IGNORE_ZERO=0 twin), then randomized traffic on DEPTH=1 and DEPTH=5 against a queue model.
module tb_rd_delay_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- directed group: WIDTH=5, DEPTH=3 ----------------
    logic       reset, stall, flush, in_valid;
    logic [4:0] in_data, rs1, rs2;
    logic       a_ov, a_h1, a_h2, z_ov, z_h1, z_h2;
    logic [4:0] a_od, z_od;
    logic [1:0] a_s1, a_s2, a_occ, z_s1, z_s2, z_occ;

    rd_delay_pipe #(.WIDTH(5), .DEPTH(3), .IGNORE_ZERO(1'b1)) dut_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .rs1(rs1), .rs2(rs2), .out_valid(a_ov), .out_data(a_od),
        .rs1_hit(a_h1), .rs1_hit_stage(a_s1), .rs2_hit(a_h2), .rs2_hit_stage(a_s2),
        .occupancy(a_occ));

    rd_delay_pipe #(.WIDTH(5), .DEPTH(3), .IGNORE_ZERO(1'b0)) dut_z (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .rs1(rs1), .rs2(rs2), .out_valid(z_ov), .out_data(z_od),
        .rs1_hit(z_h1), .rs1_hit_stage(z_s1), .rs2_hit(z_h2), .rs2_hit_stage(z_s2),
        .occupancy(z_occ));

    typedef struct {
        int r, st, fl, iv, id, rs1, rs2;
        int ov, od, occ, h1, s1, h2, s2, zh, zs;
    } vec_t;
    vec_t tv[$];

    // ---------------- random group: WIDTH=6, DEPTH=1 and DEPTH=5 ----------------
    logic       r_reset, r_stall, r_flush, r_valid;
    logic [5:0] r_data, r_rs1, r_rs2;
    logic       b_ov, b_h1, b_h2, c_ov, c_h1, c_h2;
    logic [5:0] b_od, c_od;
    logic [0:0] b_s1, b_s2, b_occ;
    logic [2:0] c_s1, c_s2, c_occ;

    rd_delay_pipe #(.WIDTH(6), .DEPTH(1)) dut_b (
        .clk(clk), .reset(r_reset), .stall(r_stall), .flush(r_flush), .in_valid(r_valid),
        .in_data(r_data), .rs1(r_rs1), .rs2(r_rs2), .out_valid(b_ov), .out_data(b_od),
        .rs1_hit(b_h1), .rs1_hit_stage(b_s1), .rs2_hit(b_h2), .rs2_hit_stage(b_s2),
        .occupancy(b_occ));

    rd_delay_pipe #(.WIDTH(6), .DEPTH(5)) dut_c (
        .clk(clk), .reset(r_reset), .stall(r_stall), .flush(r_flush), .in_valid(r_valid),
        .in_data(r_data), .rs1(r_rs1), .rs2(r_rs2), .out_valid(c_ov), .out_data(c_od),
        .rs1_hit(c_h1), .rs1_hit_stage(c_s1), .rs2_hit(c_h2), .rs2_hit_stage(c_s2),
        .occupancy(c_occ));

    // Reference: each model is a queue of {valid, tag}, index 0 youngest, last = output.
    logic [6:0] mq[2][$];
    int         dep[2] = '{1, 5};

    function automatic int youngest(input int k, input logic [5:0] rs);
        if (rs == 6'd0) return -1;
        foreach (mq[k][i]) if (mq[k][i][6] && mq[k][i][5:0] == rs) return i;
        return -1;
    endfunction

    function automatic int count_valid(input int k);
        int n = 0;
        foreach (mq[k][i]) n += int'(mq[k][i][6]);
        return n;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (r_reset || r_flush) begin
                mq[k].delete();
                for (int j = 0; j < dep[k]; j++) mq[k].push_back(7'd0);
            end else if (!r_stall) begin
                mq[k].push_front({r_valid, r_valid ? r_data : 6'd0});
                void'(mq[k].pop_back());
            end
        end
    endtask

    task automatic check_model(input int k, input string tag, input int ov, input int od,
                               input int occ, input int h1, input int s1, input int h2,
                               input int s2);
        int y1, y2;
        logic [6:0] last;
        y1   = youngest(k, r_rs1);
        y2   = youngest(k, r_rs2);
        last = mq[k][dep[k]-1];
        check({tag, " out_valid"}, ov, int'(last[6]));
        check({tag, " out_data"}, od, int'(last[5:0]));
        check({tag, " occupancy"}, occ, count_valid(k));
        check({tag, " rs1_hit"}, h1, int'(y1 >= 0));
        check({tag, " rs1_stage"}, s1, (y1 >= 0) ? y1 : 0);
        check({tag, " rs2_hit"}, h2, int'(y2 >= 0));
        check({tag, " rs2_stage"}, s2, (y2 >= 0) ? y2 : 0);
    endtask

    initial begin
        //            r st fl iv id rs1 rs2 | ov od occ h1 s1 h2 s2 zh zs
        tv.push_back('{1, 0, 0, 1, 7,  0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 0});
        tv.push_back('{1, 0, 0, 1, 7,  0, 0,   0, 0, 0,  0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 1, 7,  7, 0,   0, 0, 1,  1, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 0, 0, 0,  7, 0,   0, 0, 1,  1, 1, 0, 0, 1, 1});
        tv.push_back('{0, 0, 0, 0, 0,  7, 0,   1, 7, 1,  1, 2, 0, 0, 1, 2});
        tv.push_back('{0, 0, 0, 0, 0,  7, 0,   0, 0, 0,  0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 1, 3,  3, 5,   0, 0, 1,  1, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 0, 1, 5,  3, 5,   0, 0, 2,  1, 1, 1, 0, 1, 1});
        tv.push_back('{0, 1, 0, 1, 9,  3, 5,   0, 0, 2,  1, 1, 1, 0, 1, 1});
        tv.push_back('{0, 1, 0, 1, 9,  3, 5,   0, 0, 2,  1, 1, 1, 0, 1, 1});
        tv.push_back('{0, 0, 0, 1, 9,  5, 9,   1, 3, 3,  1, 1, 1, 0, 1, 1});
        tv.push_back('{0, 1, 1, 1, 12, 12, 9,  0, 0, 0,  0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 0, 0,  12, 9,  0, 0, 0,  0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 0, 0,  12, 9,  0, 0, 0,  0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 0, 0,  12, 9,  0, 0, 0,  0, 0, 0, 0, 0, 0});
        tv.push_back('{0, 0, 0, 1, 3,  3, 5,   0, 0, 1,  1, 0, 0, 0, 1, 0});
        tv.push_back('{0, 0, 0, 1, 5,  3, 5,   0, 0, 2,  1, 1, 1, 0, 1, 1});
        tv.push_back('{0, 0, 0, 1, 3,  3, 5,   1, 3, 3,  1, 0, 1, 1, 1, 0});
        tv.push_back('{0, 0, 0, 1, 0,  0, 3,   1, 5, 3,  0, 0, 1, 1, 1, 0});
        tv.push_back('{0, 0, 0, 1, 7,  0, 3,   1, 3, 3,  0, 0, 1, 2, 1, 1});
        tv.push_back('{0, 0, 0, 0, 0,  0, 7,   1, 0, 2,  0, 0, 1, 1, 1, 2});
        tv.push_back('{0, 0, 0, 0, 0,  0, 7,   1, 7, 1,  0, 0, 1, 2, 0, 0});
        tv.push_back('{0, 0, 0, 0, 0,  0, 7,   0, 0, 0,  0, 0, 0, 0, 0, 0});

        r_reset = 1'b1; r_stall = 1'b0; r_flush = 1'b0; r_valid = 1'b0;
        r_data = '0; r_rs1 = '0; r_rs2 = '0;

        foreach (tv[i]) begin
            reset    = tv[i].r[0];
            stall    = tv[i].st[0];
            flush    = tv[i].fl[0];
            in_valid = tv[i].iv[0];
            in_data  = tv[i].id[4:0];
            rs1      = tv[i].rs1[4:0];
            rs2      = tv[i].rs2[4:0];
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), int'(a_ov), tv[i].ov);
            check($sformatf("v%0d out_data", i), int'(a_od), tv[i].od);
            check($sformatf("v%0d occupancy", i), int'(a_occ), tv[i].occ);
            check($sformatf("v%0d rs1_hit", i), int'(a_h1), tv[i].h1);
            check($sformatf("v%0d rs1_stage", i), int'(a_s1), tv[i].s1);
            check($sformatf("v%0d rs2_hit", i), int'(a_h2), tv[i].h2);
            check($sformatf("v%0d rs2_stage", i), int'(a_s2), tv[i].s2);
            check($sformatf("v%0d z_rs1_hit", i), int'(z_h1), tv[i].zh);
            check($sformatf("v%0d z_rs1_stage", i), int'(z_s1), tv[i].zs);
        end

        reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; rs1 = '0; rs2 = '0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            r_reset = (cyc == 0) || ($urandom_range(0, 99) < 3);
            r_flush = ($urandom_range(0, 99) < 5);
            r_stall = ($urandom_range(0, 99) < 20);
            r_valid = ($urandom_range(0, 99) < 70);
            r_data  = 6'($urandom_range(0, 7));
            r_rs1   = 6'($urandom_range(0, 7));
            r_rs2   = 6'($urandom_range(0, 7));
            model_edge();
            @(posedge clk);
            #1;
            check_model(0, "d1", int'(b_ov), int'(b_od), int'(b_occ), int'(b_h1),
                        int'(b_s1), int'(b_h2), int'(b_s2));
            check_model(1, "d5", int'(c_ov), int'(c_od), int'(c_occ), int'(c_h1),
                        int'(c_s1), int'(c_h2), int'(c_s2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
